pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//   Parametrised pipeline-stage register with valid/ready handshake, 2-entry skid buffer and sync flush.
//   Successor to the plain reset flop used between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Sustains 1 transfer/cycle with a registered in_ready, so downstream stalls never form a comb path upstream.
//   Flush clears in-flight entries on branch/exception redirect.
// PARAMETERS
//   WIDTH     32  payload width in bits (>=1)
//   RESET_VAL 0   value loaded into the main and skid payload registers on reset
//   CNT_W     16  width of the perf counters (only used with PIPE_PERF_CNT_EN)
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      reset, asynchronous, active-high
//   flush      in   1      sync flush; drops all stored entries
//   in_valid   in   1      upstream has data
//   in_ready   out  1      stage can accept; = (state != FULL)
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      main entry holds valid data
//   out_ready  in   1      downstream accepts
//   out_data   out  WIDTH  main entry payload
//   stall_cnt  out  CNT_W  cycles with out_valid & !out_ready (0 when feature off)
//   flush_cnt  out  CNT_W  flushes that discarded >=1 valid entry (0 when feature off)
// BEHAVIOUR
//   Reset: state=EMPTY, out_valid=0, in_ready=1, main=skid=RESET_VAL, counters=0.
//   Transfers: acc = in_valid & in_ready; pop = out_valid & out_ready.
//   States: EMPTY (none), BUSY (main valid), FULL (main+skid valid).
//     EMPTY: acc -> BUSY, main<=in_data.
//     BUSY : acc&pop -> BUSY, main<=in_data; acc&!pop -> FULL, skid<=in_data;
//            !acc&pop -> EMPTY; else hold.
//     FULL : in_ready=0 so acc impossible; pop -> BUSY, main<=skid; else hold.
//   Latency: 1 cycle in_data -> out_data. Order strictly FIFO; no duplication or loss.
//   in_ready depends only on state regs; out_valid = (state != EMPTY).
//   out_data, out_valid stay stable while out_valid & !out_ready.
//   flush: highest priority. Next state EMPTY. Same-cycle acc and pop are discarded.
//     Payload regs keep their values (don't-care). in_ready=1 the next cycle.
//   rst mid-transfer: immediate return to reset values; no partial state survives.
//   Data on in_data is ignored when !in_valid.
// CONFIGURATION
//   `PIPE_PERF_CNT_EN defined:
//     stall_cnt +1 each cycle with out_valid & !out_ready & !flush.
//     flush_cnt +1 each flush cycle with state != EMPTY.
//     Both saturate at 2^CNT_W-1; cleared only by rst.
//   Undefined: counters not instantiated; stall_cnt/flush_cnt tied to 0; port list unchanged.
// STRUCTURE
//   pipe_pkg: state encodings ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2 and the state typedef,
//     shared with hazard unit and other pipeline stages.
//   Sub-module sat_counter #(CNT_W) (clk, rst, inc, cnt): two instances, under the macro only.
//   Top holds the FSM, main/skid regs and handshake logic.
// TESTING
//   1 Reset: assert rst mid-sim -> out_valid=0, in_ready=1, out_data=RESET_VAL immediately (async).
//   2 Streaming: in_valid=1 and out_ready=1 for 8 cycles, data 1..8 -> out 1..8, each 1 cycle later,
//     in_ready stays 1.
//   3 Backpressure: out_ready=0 while sending A,B -> state FULL, in_ready=0, out_data=A held;
//     C offered is not accepted; out_ready=1 -> A, B, C delivered in order.
//   4 Flush in FULL with in_valid=1 (D) -> next cycle out_valid=0, in_ready=1, D never appears;
//     flush_cnt=1 (macro on).
//   5 Simultaneous acc&pop in BUSY for 4 cycles -> state stays BUSY, no bubble, no drop.
//   6 Macro on, CNT_W=4, out_ready=0 for 20 cycles -> stall_cnt saturates at 15;
//     macro off -> stall_cnt=flush_cnt=0 throughout.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-stage state encodings
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, cleared only by reset
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline register with 2-entry skid buffer and flush
// Optional perf counters enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             main_load;
  logic             main_from_skid;
  logic             skid_load;
  logic             acc;
  logic             pop;

  // Handshake outputs come straight from the state register: no comb path from out_ready.
  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            state_next = ST_BUSY;
            main_load  = 1'b1;
          end
        end
        ST_BUSY: begin
          if (acc && pop) begin
            main_load = 1'b1;
          end else if (acc) begin
            state_next = ST_FULL;
            skid_load  = 1'b1;
          end else if (pop) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_next     = ST_BUSY;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      if (main_load) begin
        main_q <= main_from_skid ? skid_q : in_data;
      end
      if (skid_load) begin
        skid_q <= in_data;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid & ~out_ready & ~flush),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush & (state != ST_EMPTY)),
    .cnt (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;

  localparam int         WIDTH = 8;
  localparam int         CNT_W = 4;
  localparam logic [7:0] RV    = 8'hA5;

`ifdef PIPE_PERF_CNT_EN
  localparam int EXP_FLUSH1 = 1;
  localparam int EXP_STALL10 = 10;
  localparam int EXP_STALL20 = 15;
`else
  localparam int EXP_FLUSH1 = 0;
  localparam int EXP_STALL10 = 0;
  localparam int EXP_STALL20 = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RV),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: power-on reset
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'(RV));
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 2: streaming 1..8
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 8'(i);
      step();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data", 32'(out_data), 32'(i));
      check("stream_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    in_data  = 8'hEE;
    step();
    check("stream_drain", 32'(out_valid), 32'd0);

    // 3: backpressure A, B, C
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h0A;
    step();
    check("bp_a_data", 32'(out_data), 32'h0A);
    check("bp_a_ready", 32'(in_ready), 32'd1);
    in_data = 8'h0B;
    step();
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_full_data", 32'(out_data), 32'h0A);
    in_data = 8'h0C;
    step();
    check("bp_hold_data", 32'(out_data), 32'h0A);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_c_blocked", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    check("bp_b_data", 32'(out_data), 32'h0B);
    check("bp_b_ready", 32'(in_ready), 32'd1);
    step();
    check("bp_c_data", 32'(out_data), 32'h0C);
    in_valid = 1'b0;
    step();
    check("bp_drain", 32'(out_valid), 32'd0);

    // 4: flush in FULL with D offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    step();
    in_data = 8'h22;
    step();
    check("fl_full", 32'(in_ready), 32'd0);
    flush     = 1'b1;
    in_data   = 8'hDD;
    out_ready = 1'b1;
    step();
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready), 32'd1);
    check("fl_cnt", 32'(flush_cnt), 32'(EXP_FLUSH1));
    in_valid = 1'b0;
    step();
    check("fl_no_d", 32'(out_valid), 32'd0);
    check("fl_empty_cnt", 32'(flush_cnt), 32'(EXP_FLUSH1));
    step();
    check("fl_empty_nocount", 32'(flush_cnt), 32'(EXP_FLUSH1));
    flush = 1'b0;

    // 5: acc & pop in BUSY for 4 cycles
    in_valid = 1'b1;
    in_data  = 8'h30;
    step();
    for (int i = 1; i <= 4; i++) begin
      in_data = 8'(8'h30 + i);
      step();
      check("ap_valid", 32'(out_valid), 32'd1);
      check("ap_data", 32'(out_data), 32'(8'h30 + i));
      check("ap_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("ap_drain", 32'(out_valid), 32'd0);

    // 1: asynchronous reset mid-transfer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    step();
    in_data = 8'h66;
    step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_data", 32'(out_data), 32'(RV));
    check("arst_stall", 32'(stall_cnt), 32'd0);
    check("arst_flush", 32'(flush_cnt), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // 6: stall counter saturation
    in_valid = 1'b1;
    in_data  = 8'h40;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("stall_10", 32'(stall_cnt), 32'(EXP_STALL10));
    for (int i = 0; i < 10; i++) step();
    check("stall_sat", 32'(stall_cnt), 32'(EXP_STALL20));
    check("stall_data", 32'(out_data), 32'h40);
    check("stall_flushcnt", 32'(flush_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
